operand_fwd_ctrl: RTL and testbench

- Forwarding and load-use hazard controller for the EX-stage operand select logic.
- Tracks destination-register records of instructions in EX and MEM.
- Produces registered 2-bit selects (sel_a, sel_b) that drive the two 32-bit 3:1 operand muxes in EX: 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data.
- Raises a one-cycle stall on load-use hazards and keeps a saturating stall counter.

---
 rtl/operand_fwd_ctrl.sv | 94 +++++++++
 tb/tb_operand_fwd_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/operand_fwd_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Tracks the destination records of the EX and MEM instructions and registers the 3:1 mux selects.
module operand_fwd_ctrl #(
  parameter int RW           = 6,
  parameter int HAS_ZERO_REG = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [RW-1:0]    dec_rs,
  input  logic [RW-1:0]    dec_rt,
  input  logic [RW-1:0]    dec_rd,
  input  logic             dec_wr,
  input  logic             dec_load,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // EX record (_p1) and MEM record (_p2). MEM keeps no load flag: a load
  // that has reached MEM forwards from writeback like any other producer.
  logic          vld_p1;
  logic [RW-1:0] rd_p1;
  logic          load_p1;
  logic          vld_p2;
  logic [RW-1:0] rd_p2;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic advance;

  function automatic logic src_hit(input logic v, input logic [RW-1:0] rd,
                                   input logic [RW-1:0] src, input logic dv);
    return dv && v && (rd == src) && !((HAS_ZERO_REG != 0) && (src == '0));
  endfunction

  // Most recent producer wins: EX result beats MEM writeback data.
  function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)  return SEL_ALU;
    if (mem_hit) return SEL_WB;
    return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign ex_hit_a  = src_hit(vld_p1, rd_p1, dec_rs, dec_valid);
  assign ex_hit_b  = src_hit(vld_p1, rd_p1, dec_rt, dec_valid);
  assign mem_hit_a = src_hit(vld_p2, rd_p2, dec_rs, dec_valid);
  assign mem_hit_b = src_hit(vld_p2, rd_p2, dec_rt, dec_valid);

  assign stall   = !flush && dec_valid && vld_p1 && load_p1 && (ex_hit_a || ex_hit_b);
  assign advance = !stall && !flush;

  // ---- decode -> EX / EX -> MEM boundary: control ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      sel_a     <= SEL_RF;
      sel_b     <= SEL_RF;
      stall_cnt <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (advance) begin
        vld_p1 <= dec_valid && dec_wr;
        sel_a  <= pick_sel(ex_hit_a, mem_hit_a);
        sel_b  <= pick_sel(ex_hit_b, mem_hit_b);
      end else begin
        vld_p1 <= 1'b0;
        sel_a  <= SEL_RF;
        sel_b  <= SEL_RF;
      end
    end
  end

  // ---- decode -> EX / EX -> MEM boundary: record payload ----
  always_ff @(posedge clk) begin
    rd_p2 <= rd_p1;
    if (advance) begin
      rd_p1   <= dec_rd;
      load_p1 <= dec_load;
    end
  end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: a default instance and a zero-register,
// 4-bit-counter instance share one decode stimulus stream.
module tb_operand_fwd_ctrl;
  localparam int RW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, dec_valid, dec_wr, dec_load, flush;
  logic [RW-1:0] dec_rs, dec_rt, dec_rd;
  logic [1:0]    sel_a, sel_b, sel_a_z, sel_b_z;
  logic          stall, stall_z;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt_z;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] az;
    logic [1:0] bz;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  operand_fwd_ctrl #(.RW(RW), .HAS_ZERO_REG(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_load(dec_load), .flush(flush),
    .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  operand_fwd_ctrl #(.RW(RW), .HAS_ZERO_REG(1), .CNT_W(4)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_load(dec_load), .flush(flush),
    .sel_a(sel_a_z), .sel_b(sel_b_z), .stall(stall_z), .stall_cnt(stall_cnt_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one decode cycle, check the same-cycle stall, queue the selects
  // expected in the following cycle and compare them after the edge.
  task automatic cyc(input string tag, input logic v, input int rs, input int rt, input int rd,
                     input logic wr, input logic ld, input logic fl, input logic xs,
                     input logic [1:0] ea, input logic [1:0] eb,
                     input logic [1:0] eaz, input logic [1:0] ebz);
    exp_t e;
    dec_valid = v;
    dec_rs    = RW'(rs);
    dec_rt    = RW'(rt);
    dec_rd    = RW'(rd);
    dec_wr    = wr;
    dec_load  = ld;
    flush     = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(xs));
    chk({tag, ".stall_z"}, 32'(stall_z), 32'(xs));
    sb_q.push_back('{a: ea, b: eb, az: eaz, bz: ebz});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".sel_a"}, 32'(sel_a), 32'(e.a));
    chk({tag, ".sel_b"}, 32'(sel_b), 32'(e.b));
    chk({tag, ".sel_a_z"}, 32'(sel_a_z), 32'(e.az));
    chk({tag, ".sel_b_z"}, 32'(sel_b_z), 32'(e.bz));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dec_valid = 1'($urandom);
      dec_rs    = RW'($urandom);
      dec_rt    = RW'($urandom);
      dec_rd    = RW'($urandom);
      dec_wr    = 1'($urandom);
      dec_load  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst.sel_a", 32'(sel_a), 0);
    chk("rst.sel_b", 32'(sel_b), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    chk("rst.cnt_z", 32'(stall_cnt_z), 0);
    chk("rst.stall", 32'(stall), 0);
    rst_n = 1'b1;

    //    tag       v  rs rt rd wr ld fl st ea     eb     eaz    ebz
    cyc("first",   1, 1, 2, 3, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("d1.prod", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("d1.cons", 1, 5, 7, 8, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00);
    cyc("d2.prod", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("d2.nop",  1, 1, 2, 5, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("d2.cons", 1, 5, 6, 10, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    cyc("pr.p1",   1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("pr.p2",   1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("pr.cons", 1, 5, 5, 10, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b01);
    cyc("lu.load", 1, 1, 2, 9, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("lu.stl",  1, 3, 9, 11, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("lu.held", 1, 3, 9, 11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    chk("lu.cnt", 32'(stall_cnt), 1);
    chk("lu.cnt_z", 32'(stall_cnt_z), 1);
    cyc("fl.load", 1, 1, 2, 9, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("fl.cons", 1, 9, 4, 11, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("fl.cnt", 32'(stall_cnt), 1);
    cyc("memld",   1, 2, 9, 11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    cyc("z.prod",  1, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("z.cons",  1, 0, 3, 11, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc("sq.load", 1, 1, 2, 9, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("sq.cons", 1, 9, 9, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("iv.prod", 0, 1, 2, 7, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("iv.cons", 1, 7, 7, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 20; i++) begin
      cyc("sat.load", 1, 1, 2, 9, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      cyc("sat.stl",  1, 9, 9, 11, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      cyc("sat.held", 1, 9, 9, 11, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 2'b10);
    end
    chk("sat.cnt", 32'(stall_cnt), 21);
    chk("sat.cnt_z", 32'(stall_cnt_z), 15);

    // Reset arriving while a load-use stall is being raised.
    cyc("rs.load", 1, 1, 2, 9, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    dec_rs = RW'(9);
    dec_rt = RW'(3);
    dec_wr = 1'b0;
    dec_load = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rs.stall_pre", 32'(stall), 1);
    @(posedge clk);
    #1;
    chk("rs.sel_a", 32'(sel_a), 0);
    chk("rs.sel_b", 32'(sel_b), 0);
    chk("rs.cnt", 32'(stall_cnt), 0);
    chk("rs.cnt_z", 32'(stall_cnt_z), 0);
    chk("rs.stall", 32'(stall), 0);
    rst_n = 1'b1;
    cyc("rs.after", 1, 9, 3, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("sb.empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
